// File: rtl/ysyx_pkg.sv
// rtl/ysyx_pkg.sv - shared types and constants for the ysyx core front end
package ysyx_pkg;

    localparam int XLEN   = 32;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // Instruction fetch unit states.
    typedef enum logic [1:0] {
        REQ      = 2'd0,
        RSP      = 2'd1,
        HOLD     = 2'd2,
        WAIT_NPC = 2'd3
    } ifu_state_t;

endpackage

// File: rtl/ysyx_ifu_wdog.sv
// rtl/ysyx_ifu_wdog.sv - response timeout counter for the instruction fetch unit
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   active      high while the IFU waits for a memory response
//   rsp_valid   memory response present this cycle
//   timeout     one-cycle pulse on the last allowed waiting cycle
module ysyx_ifu_wdog #(
    parameter int WDOG_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic rsp_valid,
    output logic timeout
);

    localparam int             CW    = $clog2(WDOG_CYCLES + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(WDOG_CYCLES - 1);

    logic [CW-1:0] count;

    // A response arriving on the final cycle still wins over the timeout.
    assign timeout = active && !rsp_valid && (count == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!active) begin
            // Held at zero outside the wait so each wait starts from a clean count.
            count <= '0;
        end else if (!rsp_valid && !timeout) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_ifu.sv
// rtl/ysyx_ifu.sv - instruction fetch unit: one fetch in flight, handshakes with imem, decode and writeback
//
// Optional response watchdog: define YSYX_IFU_WDOG_EN.
//
// Ports:
//   clk, rst_n                                clock, asynchronous active-low reset
//   imem_req_valid/ready, imem_req_addr       instruction memory read request
//   imem_rsp_valid/ready, imem_rsp_data/err   instruction memory read response
//   inst_valid/ready, inst, pc, inst_err      fetched instruction to decode
//   npc_valid, npc                            next pc from writeback
module ysyx_ifu
    import ysyx_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int              WDOG_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst_n,

    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,

    input  logic              imem_rsp_valid,
    output logic              imem_rsp_ready,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              imem_rsp_err,

    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   pc,
    output logic              inst_err,

    input  logic              npc_valid,
    input  logic [XLEN-1:0]   npc
);

    ifu_state_t state;
    logic       timeout;
    logic       npc_take;
    logic       npc_misaligned;

`ifdef YSYX_IFU_WDOG_EN
    ysyx_ifu_wdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (state == RSP),
        .rsp_valid (imem_rsp_valid),
        .timeout   (timeout)
    );
`else
    logic unused_wdog_cycles;
    assign timeout            = 1'b0;
    assign unused_wdog_cycles = (WDOG_CYCLES == 0);
`endif

    // Reset leaves the state at REQ, so the request valid is masked by rst_n
    // to keep it low while reset is held.
    assign imem_req_valid = rst_n && (state == REQ);
    assign imem_req_addr  = pc;
    assign imem_rsp_ready = (state == RSP);
    assign inst_valid     = (state == HOLD);

    // Writeback may hand over the next pc in the same cycle decode accepts.
    assign npc_take       = npc_valid && ((state == WAIT_NPC) || ((state == HOLD) && inst_ready));
    assign npc_misaligned = (npc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= REQ;
            pc       <= RESET_PC;
            inst     <= '0;
            inst_err <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    if (imem_req_ready) begin
                        state <= RSP;
                    end
                end
                RSP: begin
                    if (imem_rsp_valid) begin
                        inst     <= imem_rsp_data;
                        inst_err <= imem_rsp_err;
                        state    <= HOLD;
                    end else if (timeout) begin
                        inst     <= '0;
                        inst_err <= 1'b1;
                        state    <= HOLD;
                    end
                end
                HOLD, WAIT_NPC: begin
                    if (npc_take) begin
                        pc <= npc;
                        if (npc_misaligned) begin
                            // Fault is reported straight to decode; memory is never touched.
                            inst     <= '0;
                            inst_err <= 1'b1;
                            state    <= HOLD;
                        end else begin
                            state <= REQ;
                        end
                    end else if ((state == HOLD) && inst_ready) begin
                        state <= WAIT_NPC;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

    // Writeback must not deliver a next pc while a fetch is still in progress.
    a_npc_in_fetch: assert property (@(posedge clk) disable iff (!rst_n)
        !(npc_valid && ((state == REQ) || (state == RSP))));

endmodule

// File: tb/tb_ysyx_ifu.sv
// tb/tb_ysyx_ifu.sv - self-checking bench for ysyx_ifu
module tb_ysyx_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic        imem_rsp_ready;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_err;
    logic        npc_valid;
    logic [31:0] npc;

    int          n_cmp;
    int          n_bad;
    int          req_hs_total;
    logic [31:0] cur_pc;

    ysyx_ifu #(
        .RESET_PC    (RST_PC),
        .WDOG_CYCLES (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_ready (imem_rsp_ready),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .pc             (pc),
        .inst_err       (inst_err),
        .npc_valid      (npc_valid),
        .npc            (npc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_req_valid && imem_req_ready) req_hs_total <= req_hs_total + 1;
    end

    // Memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9e37_79b9) ^ 32'h0000_0013;
    endfunction

    // Plays the memory side of one fetch: waits for the request, stalls ready,
    // optionally drives a stray response in the handshake cycle, then answers.
    task automatic mem_serve(input int req_delay, input int rsp_delay, input logic [31:0] data,
                             input logic err, input logic junk, output logic [31:0] addr_seen,
                             output logic stable, output logic ok);
        int n;
        stable = 1'b1; ok = 1'b1; addr_seen = '0; n = 0;
        while (imem_req_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (imem_req_valid !== 1'b1) begin ok = 1'b0; return; end
        addr_seen = imem_req_addr;
        for (int i = 0; i < req_delay; i++) begin
            imem_req_ready = 1'b0;
            @(negedge clk);
            if (imem_req_valid !== 1'b1 || imem_req_addr !== addr_seen) stable = 1'b0;
        end
        imem_req_ready = 1'b1;
        if (junk) begin imem_rsp_valid = 1'b1; imem_rsp_data = 32'hdead_beef; imem_rsp_err = 1'b1; end
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < rsp_delay; i++) @(negedge clk);
        imem_rsp_valid = 1'b1; imem_rsp_data = data; imem_rsp_err = err;
        @(negedge clk);
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
    endtask

    task automatic wait_inst(output logic ok);
        int n;
        n = 0;
        while (inst_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        ok = (inst_valid === 1'b1);
    endtask

    // Decode side: holds inst_ready low for a while (reporting whether the
    // presented instruction stayed put), then accepts, optionally with npc.
    task automatic dec_accept(input int delay, input logic with_npc, input logic [31:0] npc_v,
                              output logic stable);
        logic [31:0] i0, p0;
        logic        e0;
        i0 = inst; p0 = pc; e0 = inst_err; stable = 1'b1;
        for (int i = 0; i < delay; i++) begin
            inst_ready = 1'b0;
            @(negedge clk);
            if (inst_valid !== 1'b1 || inst !== i0 || pc !== p0 || inst_err !== e0) stable = 1'b0;
        end
        inst_ready = 1'b1;
        if (with_npc) begin npc_valid = 1'b1; npc = npc_v; end
        @(negedge clk);
        inst_ready = 1'b0; npc_valid = 1'b0;
    endtask

    task automatic send_npc(input logic [31:0] v, input int delay);
        for (int i = 0; i < delay; i++) @(negedge clk);
        npc_valid = 1'b1; npc = v;
        @(negedge clk);
        npc_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0; imem_rsp_err = 0;
        inst_ready = 0; npc_valid = 0; npc = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        n_cmp++; if (imem_rsp_ready !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_ready: got %b want 0", imem_rsp_ready); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
        n_cmp++; if (pc !== RST_PC) begin n_bad++; $display("FAIL reset_pc: got %h want %h", pc, RST_PC); end
        n_cmp++; if (inst !== 32'h0 || inst_err !== 1'b0) begin n_bad++; $display("FAIL reset_inst: got %h/%b want 0/0", inst, inst_err); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin n_bad++; $display("FAIL reset_release_req: got %b/%h want 1/%h", imem_req_valid, imem_req_addr, RST_PC); end
        @(negedge clk);
        cur_pc = RST_PC;
    endtask

    task automatic test_basic_fetch;
        logic [31:0] a; logic st, ok;
        mem_serve(0, 1, 32'h0010_0093, 1'b0, 1'b1, a, st, ok);
        n_cmp++; if (ok !== 1'b1 || a !== RST_PC) begin n_bad++; $display("FAIL basic_addr: got %h (ok %b) want %h", a, ok, RST_PC); end
        n_cmp++; if (inst_valid !== 1'b1) begin n_bad++; $display("FAIL basic_inst_valid: got %b want 1", inst_valid); end
        n_cmp++; if (inst !== 32'h0010_0093) begin n_bad++; $display("FAIL basic_inst: got %h want 00100093", inst); end
        n_cmp++; if (pc !== RST_PC || inst_err !== 1'b0) begin n_bad++; $display("FAIL basic_pc_err: got %h/%b want %h/0", pc, inst_err, RST_PC); end
    endtask

    task automatic test_hold_stall;
        logic st;
        dec_accept(3, 1'b0, '0, st);
        n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL hold_stable: got %b want 1", st); end
        n_cmp++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL hold_wait_idle: got %b/%b want 0/0", inst_valid, imem_req_valid); end
        send_npc(32'h8000_0004, 1);
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004) begin n_bad++; $display("FAIL npc_latency: got %b/%h want 1/80000004", imem_req_valid, imem_req_addr); end
        cur_pc = 32'h8000_0004;
    endtask

    task automatic test_req_stall;
        logic [31:0] a; logic st, ok; int hs0;
        hs0 = req_hs_total;
        mem_serve(5, 0, mem_word(cur_pc), 1'b0, 1'b0, a, st, ok);
        n_cmp++; if (ok !== 1'b1 || st !== 1'b1 || a !== cur_pc) begin n_bad++; $display("FAIL req_stall_stable: got ok %b stable %b addr %h want 1 1 %h", ok, st, a, cur_pc); end
        n_cmp++; if (req_hs_total - hs0 !== 1) begin n_bad++; $display("FAIL req_stall_handshakes: got %0d want 1", req_hs_total - hs0); end
        n_cmp++; if (inst_valid !== 1'b1 || inst !== mem_word(cur_pc) || pc !== cur_pc) begin n_bad++; $display("FAIL req_stall_inst: got %b/%h/%h want 1/%h/%h", inst_valid, inst, pc, mem_word(cur_pc), cur_pc); end
        dec_accept(0, 1'b0, '0, st);
    endtask

    task automatic test_misaligned;
        logic st; int hs0;
        hs0 = req_hs_total;
        send_npc(32'h8000_0006, 0);
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL misaligned_no_req: got %b want 0", imem_req_valid); end
        n_cmp++; if (inst_valid !== 1'b1 || inst !== 32'h0 || inst_err !== 1'b1 || pc !== 32'h8000_0006) begin n_bad++; $display("FAIL misaligned_inst: got %b/%h/%b/%h want 1/0/1/80000006", inst_valid, inst, inst_err, pc); end
        n_cmp++; if (req_hs_total != hs0) begin n_bad++; $display("FAIL misaligned_handshakes: got %0d want 0", req_hs_total - hs0); end
        // Next pc delivered together with the decode handshake.
        dec_accept(0, 1'b1, 32'h8000_0008, st);
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0008) begin n_bad++; $display("FAIL hold_npc_same_cycle: got %b/%h want 1/80000008", imem_req_valid, imem_req_addr); end
        cur_pc = 32'h8000_0008;
    endtask

    task automatic test_rsp_err;
        logic [31:0] a; logic st, ok;
        mem_serve(0, 2, 32'h1234_5678, 1'b1, 1'b0, a, st, ok);
        n_cmp++; if (inst !== 32'h1234_5678 || inst_err !== 1'b1 || pc !== cur_pc) begin n_bad++; $display("FAIL rsp_err_inst: got %h/%b/%h want 12345678/1/%h", inst, inst_err, pc, cur_pc); end
        dec_accept(1, 1'b0, '0, st);
        send_npc(32'h8000_000c, 0);
        cur_pc = 32'h8000_000c;
        mem_serve(1, 0, mem_word(cur_pc), 1'b0, 1'b0, a, st, ok);
        n_cmp++; if (a !== cur_pc || inst !== mem_word(cur_pc) || inst_err !== 1'b0) begin n_bad++; $display("FAIL rsp_err_recover: got %h/%h/%b want %h/%h/0", a, inst, inst_err, cur_pc, mem_word(cur_pc)); end
        dec_accept(0, 1'b0, '0, st);
        send_npc(32'h8000_0010, 0);
        cur_pc = 32'h8000_0010;
    endtask

    // Random program flow against a model of what each fetch must present:
    // aligned pc -> one memory read returning mem_word(pc) and the chosen error;
    // misaligned pc -> no memory read, inst 0 with a fault.
    task automatic test_random;
        logic [31:0] a, exp_inst, nxt; logic st, ok, exp_err, mis; int hs0;
        mis = 1'b0;
        for (int it = 0; it < 30; it++) begin
            hs0 = req_hs_total;
            if (!mis) begin
                exp_inst = mem_word(cur_pc);
                exp_err  = ($urandom_range(0, 3) == 0);
                mem_serve($urandom_range(0, 3), $urandom_range(0, 3), exp_inst, exp_err, 1'($urandom_range(0, 1)), a, st, ok);
                n_cmp++; if (ok !== 1'b1 || st !== 1'b1 || a !== cur_pc) begin n_bad++; $display("FAIL rand_req it%0d: got ok %b stable %b addr %h want 1 1 %h", it, ok, st, a, cur_pc); end
            end else begin
                exp_inst = 32'h0;
                exp_err  = 1'b1;
            end
            wait_inst(ok);
            n_cmp++; if (ok !== 1'b1 || inst !== exp_inst || pc !== cur_pc || inst_err !== exp_err) begin n_bad++; $display("FAIL rand_inst it%0d: got %b/%h/%h/%b want 1/%h/%h/%b", it, ok, inst, pc, inst_err, exp_inst, cur_pc, exp_err); end
            n_cmp++; if (req_hs_total - hs0 !== (mis ? 0 : 1)) begin n_bad++; $display("FAIL rand_handshakes it%0d: got %0d want %0d", it, req_hs_total - hs0, mis ? 0 : 1); end
            nxt = 32'h8000_0000 | ($urandom() & 32'h0000_fffc);
            if (it != 29 && $urandom_range(0, 3) == 0) nxt[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) begin
                dec_accept($urandom_range(0, 3), 1'b1, nxt, st);
            end else begin
                dec_accept($urandom_range(0, 3), 1'b0, '0, st);
                send_npc(nxt, $urandom_range(0, 3));
            end
            n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL rand_hold_stable it%0d: got %b want 1", it, st); end
            cur_pc = nxt;
            mis = (nxt[1:0] != 2'b00);
        end
    endtask

`ifdef YSYX_IFU_WDOG_EN
    task automatic test_wdog;
        int k; logic st;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        k = 0;
        while (inst_valid !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        n_cmp++; if (k != 8) begin n_bad++; $display("FAIL wdog_latency: got %0d want 8", k); end
        n_cmp++; if (inst !== 32'h0 || inst_err !== 1'b1 || imem_rsp_ready !== 1'b0) begin n_bad++; $display("FAIL wdog_fault: got %h/%b/%b want 0/1/0", inst, inst_err, imem_rsp_ready); end
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        n_cmp++; if (inst !== 32'h0 || inst_valid !== 1'b1) begin n_bad++; $display("FAIL wdog_late_drop: got %h/%b want 0/1", inst, inst_valid); end
        dec_accept(0, 1'b0, '0, st);
        send_npc(32'h8000_0100, 0);
        cur_pc = 32'h8000_0100;
    endtask
`endif

    task automatic test_reset_mid;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        n_cmp++; if (imem_rsp_ready !== 1'b1) begin n_bad++; $display("FAIL mid_in_rsp: got %b want 1", imem_rsp_ready); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b0 || imem_rsp_ready !== 1'b0 || inst_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_ctrl: got %b/%b/%b want 0/0/0", imem_req_valid, imem_rsp_ready, inst_valid); end
        n_cmp++; if (pc !== RST_PC || inst !== 32'h0 || inst_err !== 1'b0) begin n_bad++; $display("FAIL mid_reset_data: got %h/%h/%b want %h/0/0", pc, inst, inst_err, RST_PC); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin n_bad++; $display("FAIL mid_release: got %b/%h want 1/%h", imem_req_valid, imem_req_addr, RST_PC); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; req_hs_total = 0; cur_pc = RST_PC;
        test_reset;
        test_basic_fetch;
        test_hold_stall;
        test_req_stall;
        test_misaligned;
        test_rsp_err;
        test_random;
`ifdef YSYX_IFU_WDOG_EN
        test_wdog;
`endif
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
